// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO, configurable framing and bit period.
// Frames leave back-to-back whenever the FIFO still holds data at the end of a stop bit.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 12,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          ovf_clr,
  output logic                          dbf,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic                          tdf,
  output logic                          Txd
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e               state_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bitIdx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 txd_q;
  logic                 tdf_q;

  logic                 push;
  logic                 pop;
  logic                 bitEnd;
  logic [DATA_BITS-1:0] head;
  logic                 headParity;

  assign dbf   = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign ovf   = ovf_q;
  assign tdf   = tdf_q;
  assign Txd   = txd_q;

  assign push       = wr && !dbf;
  assign bitEnd     = (cnt_q == CNT_LAST);
  assign pop        = !empty && ((state_q == IDLE) ||
                      (state_q == STOP && bitEnd && bitIdx_q == STOP_LAST));
  assign head       = mem_q[rdPtr_q];
  assign headParity = (PARITY == 1) ? ~^head : ^head;

  // Full is judged on the registered level, so a same-cycle pop never admits a write into a full FIFO.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (wr && dbf)    ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      tdf_q    <= 1'b0;
    end else begin
      if (tdf_q && !bitEnd) cnt_q <= cnt_q + CNT_W'(1);
      else                  cnt_q <= '0;

      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q  <= head;
            parity_q <= headParity;
            txd_q    <= 1'b0;
            tdf_q    <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            txd_q    <= shift_q[0];
            shift_q  <= shift_q >> 1;
            bitIdx_q <= '0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitIdx_q == DATA_LAST) begin
              if (PARITY != 0) begin
                txd_q   <= parity_q;
                state_q <= PAR;
              end else begin
                txd_q    <= 1'b1;
                bitIdx_q <= '0;
                state_q  <= STOP;
              end
            end else begin
              txd_q    <= shift_q[0];
              shift_q  <= shift_q >> 1;
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end
        end
        PAR: begin
          if (bitEnd) begin
            txd_q    <= 1'b1;
            bitIdx_q <= '0;
            state_q  <= STOP;
          end
        end
        STOP: begin
          if (bitEnd) begin
            if (bitIdx_q == STOP_LAST) begin
              // Reload on the last stop edge keeps consecutive frames gap-free.
              if (pop) begin
                shift_q  <= head;
                parity_q <= headParity;
                txd_q    <= 1'b0;
                state_q  <= START;
              end else begin
                txd_q   <= 1'b1;
                tdf_q   <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          tdf_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
